// File: rtl/fnd_pkg.sv
// Shared constants and helpers for the FND scan path: segment codes, the
// conversion FSM state type and the double-dabble digit adjust.
package fnd_pkg;

   typedef enum logic [1:0] {IDLE, CONV, DONE} conv_state_t;

   localparam logic [7:0] SEG_CODE [10] = '{
      8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
      8'h92, 8'h82, 8'hF8, 8'h80, 8'h90
   };
   localparam logic [7:0]  SEG_BLANK = 8'hFF;
   localparam logic [7:0]  SEG_DASH  = 8'hBF;
   localparam int unsigned DP_BIT    = 7;

   function automatic logic [3:0] dd_adjust(input logic [3:0] n);
      return (n >= 4'd5) ? n + 4'd3 : n;
   endfunction

   function automatic logic [7:0] seg_of(input logic [3:0] d);
      return (d <= 4'd9) ? SEG_CODE[d] : SEG_BLANK;
   endfunction

endpackage

// File: rtl/fnd_scan_ctrl_if.sv
// Value load handshake between the status logic (master) and the FND
// scan controller (slave).
interface fnd_scan_ctrl_if #(
   parameter int unsigned VALUE_W = 14
);
   logic [VALUE_W-1:0] value_i;
   logic               value_valid;
   logic               busy;
   logic               ovf;

   modport master (output value_i, value_valid, input busy, ovf);
   modport slave  (input value_i, value_valid, output busy, ovf);
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter: accepts a value on the handshake,
// runs one double-dabble shift per clock and commits the result plus overflow.
module bin2bcd_seq
   import fnd_pkg::*;
#(
   parameter int unsigned VALUE_W    = 14,
   parameter int unsigned NUM_DIGITS = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [VALUE_W-1:0]      value_i,
   input  logic                    value_valid,
   output logic                    busy,
   output logic                    ovf,
   output logic [4*NUM_DIGITS-1:0] disp_bcd
);

   localparam int unsigned BCD_W = 4 * NUM_DIGITS;
   localparam int unsigned CNT_W = $clog2(VALUE_W + 1);

   conv_state_t        state, state_nx;
   logic [CNT_W-1:0]   shift_cnt;
   logic [VALUE_W-1:0] bin_sh;
   logic [BCD_W-1:0]   bcd_sh;
   logic [BCD_W-1:0]   bcd_adj;
   logic               ovf_acc;
   logic               last_shift;

   assign last_shift = (shift_cnt == CNT_W'(VALUE_W - 1));

   always_comb begin
      bcd_adj = '0;
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
         bcd_adj[4*i +: 4] = dd_adjust(bcd_sh[4*i +: 4]);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      busy     = 1'b0;
      case (state)
         IDLE: if (value_valid) state_nx = CONV;
         CONV: begin
            busy = 1'b1;
            if (last_shift) state_nx = DONE;
         end
         DONE: begin
            busy     = 1'b1;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // Any bit leaving the top nibble means a digit beyond NUM_DIGITS is nonzero.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         shift_cnt <= '0;
         bin_sh    <= '0;
         bcd_sh    <= '0;
         ovf_acc   <= 1'b0;
         disp_bcd  <= '0;
         ovf       <= 1'b0;
      end else begin
         case (state)
            IDLE: if (value_valid) begin
               bin_sh    <= value_i;
               bcd_sh    <= '0;
               ovf_acc   <= 1'b0;
               shift_cnt <= '0;
            end
            CONV: begin
               {bcd_sh, bin_sh} <= {bcd_adj[BCD_W-2:0], bin_sh, 1'b0};
               ovf_acc          <= ovf_acc | bcd_adj[BCD_W-1];
               shift_cnt        <= shift_cnt + 1'b1;
            end
            DONE: begin
               disp_bcd <= bcd_sh;
               ovf      <= ovf_acc;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/fnd_scan_ctrl.sv
// Multi-digit common-anode FND scan controller: BCD conversion, digit scan,
// leading-zero blanking, decimal points, overflow dashes and blinking.
module fnd_scan_ctrl
   import fnd_pkg::*;
#(
   parameter int unsigned NUM_DIGITS  = 4,
   parameter int unsigned VALUE_W     = 14,
   parameter int unsigned TICK_DIV    = 100000,
   parameter int unsigned BLINK_TICKS = 500
) (
   input  logic                  clk,
   input  logic                  rst,
   fnd_scan_ctrl_if.slave        bus,
   input  logic                  blank_lz,
   input  logic [NUM_DIGITS-1:0] dp_mask,
   input  logic                  blink_en,
   output logic [NUM_DIGITS-1:0] fnd_com,
   output logic [7:0]            fnd_data
);

   localparam int unsigned IDX_W   = $clog2(NUM_DIGITS);
   localparam int unsigned TICK_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int unsigned BLINK_W = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

   logic [4*NUM_DIGITS-1:0] disp_bcd;
   logic                    conv_busy, conv_ovf;
   logic [TICK_W-1:0]       tick_cnt;
   logic                    tick;
   logic [IDX_W-1:0]        scan_idx;
   logic [BLINK_W-1:0]      blink_cnt;
   logic                    blink_phase;
   logic [NUM_DIGITS-1:0]   lz_mask;
   logic                    lz_run;
   logic [3:0]              cur_digit;
   logic [7:0]              seg_nx;
   logic [NUM_DIGITS-1:0]   com_nx;

   bin2bcd_seq #(.VALUE_W(VALUE_W), .NUM_DIGITS(NUM_DIGITS)) u_conv (
      .clk         (clk),
      .rst         (rst),
      .value_i     (bus.value_i),
      .value_valid (bus.value_valid),
      .busy        (conv_busy),
      .ovf         (conv_ovf),
      .disp_bcd    (disp_bcd)
   );

   assign bus.busy = conv_busy;
   assign bus.ovf  = conv_ovf;
   assign tick     = (tick_cnt == TICK_W'(TICK_DIV - 1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tick_cnt <= '0;
         scan_idx <= '0;
      end else if (tick) begin
         tick_cnt <= '0;
         scan_idx <= (scan_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : scan_idx + 1'b1;
      end else begin
         tick_cnt <= tick_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         blink_cnt   <= '0;
         blink_phase <= 1'b0;
      end else if (!blink_en) begin
         blink_cnt   <= '0;
         blink_phase <= 1'b0;
      end else if (tick) begin
         if (blink_cnt == BLINK_W'(BLINK_TICKS - 1)) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
         end else begin
            blink_cnt <= blink_cnt + 1'b1;
         end
      end
   end

   // lz_mask[i]: digit i and every digit above it are zero; digit 0 never blanks.
   always_comb begin
      lz_run  = 1'b1;
      lz_mask = '0;
      for (int unsigned i = NUM_DIGITS - 1; i >= 1; i--) begin
         lz_run     = lz_run & (disp_bcd[4*i +: 4] == 4'd0);
         lz_mask[i] = lz_run;
      end
   end

   always_comb begin
      cur_digit = disp_bcd[4*scan_idx +: 4];
      if (conv_ovf)                          seg_nx = SEG_DASH;
      else if (blank_lz && lz_mask[scan_idx]) seg_nx = SEG_BLANK;
      else                                   seg_nx = seg_of(cur_digit);
      if (dp_mask[scan_idx]) seg_nx[DP_BIT] = 1'b0;
      com_nx = (blink_en && blink_phase) ? '1 : ~(NUM_DIGITS'(1) << scan_idx);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fnd_com  <= '1;
         fnd_data <= SEG_BLANK;
      end else if (tick) begin
         fnd_com  <= com_nx;
         fnd_data <= seg_nx;
      end
   end

endmodule

// File: tb/tb_fnd_scan_ctrl.sv
// Directed self-checking bench for fnd_scan_ctrl with a fast scan (TICK_DIV=4)
// and short blink period (BLINK_TICKS=2).
module tb_fnd_scan_ctrl;

   localparam int unsigned ND = 4;
   localparam int unsigned VW = 14;
   localparam int unsigned TD = 4;
   localparam int unsigned BT = 2;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          blank_lz = 1'b0;
   logic          blink_en = 1'b0;
   logic [ND-1:0] dp_mask = '0;
   logic [ND-1:0] fnd_com;
   logic [7:0]    fnd_data;

   int checks = 0;
   int errors = 0;

   logic [ND-1:0] cap_com  [ND];
   logic [7:0]    cap_data [ND];
   logic          cap_ok;

   fnd_scan_ctrl_if #(.VALUE_W(VW)) bus ();

   fnd_scan_ctrl #(
      .NUM_DIGITS(ND), .VALUE_W(VW), .TICK_DIV(TD), .BLINK_TICKS(BT)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .bus      (bus),
      .blank_lz (blank_lz),
      .dp_mask  (dp_mask),
      .blink_en (blink_en),
      .fnd_com  (fnd_com),
      .fnd_data (fnd_data)
   );

   always #5 clk = ~clk;

   function automatic logic [ND-1:0] exp_com(input int i);
      return ~(ND'(1) << i);
   endfunction

   // Align to the digit-0 strobe, then record one full scan, one slot per TD clocks.
   task automatic capture_scan();
      logic [ND-1:0] prev;
      int unsigned   n;
      cap_ok = 1'b0;
      n = 0;
      while (!cap_ok && n < 64) begin
         prev = fnd_com;
         @(posedge clk); #1;
         n++;
         if (fnd_com == exp_com(0) && prev != exp_com(0)) cap_ok = 1'b1;
      end
      cap_com[0]  = fnd_com;
      cap_data[0] = fnd_data;
      for (int i = 1; i < ND; i++) begin
         repeat (TD) @(posedge clk);
         #1;
         cap_com[i]  = fnd_com;
         cap_data[i] = fnd_data;
      end
   endtask

   task automatic load(input logic [VW-1:0] v, output int unsigned busy_cycles);
      @(negedge clk);
      bus.value_i     = v;
      bus.value_valid = 1'b1;
      @(posedge clk); #1;
      bus.value_valid = 1'b0;
      busy_cycles = 0;
      while (bus.busy && busy_cycles < 100) begin
         busy_cycles++;
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset();
      rst = 1'b0;
      bus.value_i = '0;
      bus.value_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (fnd_com !== 4'b1111 || fnd_data !== 8'hFF || bus.busy !== 1'b0 || bus.ovf !== 1'b0) begin
         errors++;
         $display("FAIL reset_state: com=%b data=%h busy=%b ovf=%b required com=1111 data=FF busy=0 ovf=0",
                  fnd_com, fnd_data, bus.busy, bus.ovf);
      end
      @(negedge clk) rst = 1'b1;
      repeat (TD - 1) @(posedge clk);
      #1;
      checks++;
      if (fnd_com !== 4'b1111) begin
         errors++;
         $display("FAIL reset_pre_tick: com=%b required 1111", fnd_com);
      end
      @(posedge clk); #1;
      checks++;
      if (fnd_com !== 4'b1110 || fnd_data !== 8'hC0) begin
         errors++;
         $display("FAIL reset_first_tick: com=%b data=%h required com=1110 data=C0", fnd_com, fnd_data);
      end
   endtask

   task automatic test_load_1234();
      int unsigned bc;
      logic [7:0]  exp [ND];
      exp = '{8'h99, 8'hB0, 8'hA4, 8'hF9};
      blank_lz = 1'b1;
      load(14'd1234, bc);
      checks++;
      if (bc != 15) begin
         errors++;
         $display("FAIL busy_len_1234: busy cycles=%0d required 15", bc);
      end
      capture_scan();
      checks++;
      if (cap_ok !== 1'b1 || bus.ovf !== 1'b0) begin
         errors++;
         $display("FAIL 1234_sync: strobe=%b ovf=%b required strobe=1 ovf=0", cap_ok, bus.ovf);
      end
      for (int i = 0; i < ND; i++) begin
         checks++;
         if (cap_com[i] !== exp_com(i) || cap_data[i] !== exp[i]) begin
            errors++;
            $display("FAIL 1234_digit%0d: com=%b data=%h required com=%b data=%h",
                     i, cap_com[i], cap_data[i], exp_com(i), exp[i]);
         end
      end
   endtask

   task automatic test_blanking();
      int unsigned bc;
      logic [7:0]  exp [4][ND];
      logic        lz  [4];
      logic [ND-1:0] dpm [4];
      exp = '{'{8'hF8, 8'hFF, 8'hFF, 8'hFF},
              '{8'hF8, 8'hC0, 8'hC0, 8'hC0},
              '{8'hF8, 8'hFF, 8'h7F, 8'hFF},
              '{8'hF8, 8'hC0, 8'h40, 8'hC0}};
      lz  = '{1'b1, 1'b0, 1'b1, 1'b0};
      dpm = '{4'b0000, 4'b0000, 4'b0100, 4'b0100};
      blank_lz = 1'b1;
      dp_mask  = '0;
      load(14'd7, bc);
      for (int s = 0; s < 4; s++) begin
         blank_lz = lz[s];
         dp_mask  = dpm[s];
         capture_scan();
         for (int i = 0; i < ND; i++) begin
            checks++;
            if (cap_ok !== 1'b1 || cap_com[i] !== exp_com(i) || cap_data[i] !== exp[s][i]) begin
               errors++;
               $display("FAIL blank_s%0d_digit%0d: strobe=%b com=%b data=%h required com=%b data=%h",
                        s, i, cap_ok, cap_com[i], cap_data[i], exp_com(i), exp[s][i]);
            end
         end
      end
      dp_mask = '0;
   endtask

   task automatic test_overflow();
      int unsigned bc;
      logic [VW-1:0] vals [2];
      logic [7:0]    segs [2];
      logic          ovfs [2];
      vals = '{14'd10000, 14'd9999};
      segs = '{8'hBF, 8'h90};
      ovfs = '{1'b1, 1'b0};
      blank_lz = 1'b1;
      for (int s = 0; s < 2; s++) begin
         load(vals[s], bc);
         checks++;
         if (bus.ovf !== ovfs[s]) begin
            errors++;
            $display("FAIL ovf_flag_%0d: ovf=%b required %b", vals[s], bus.ovf, ovfs[s]);
         end
         capture_scan();
         for (int i = 0; i < ND; i++) begin
            checks++;
            if (cap_ok !== 1'b1 || cap_com[i] !== exp_com(i) || cap_data[i] !== segs[s]) begin
               errors++;
               $display("FAIL ovf_%0d_digit%0d: com=%b data=%h required com=%b data=%h",
                        vals[s], i, cap_com[i], cap_data[i], exp_com(i), segs[s]);
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      int unsigned n;
      int unsigned late_busy;
      logic [7:0]  exp [ND];
      exp = '{8'h99, 8'hB0, 8'hA4, 8'hF9};
      blank_lz = 1'b1;
      @(negedge clk);
      bus.value_i = 14'd1234;
      bus.value_valid = 1'b1;
      @(posedge clk); #1;
      bus.value_valid = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      bus.value_i = 14'd42;
      bus.value_valid = 1'b1;
      @(posedge clk); #1;
      bus.value_valid = 1'b0;
      bus.value_i = '0;
      n = 0;
      while (bus.busy && n < 100) begin
         n++;
         @(posedge clk); #1;
      end
      late_busy = 0;
      repeat (20) begin
         @(posedge clk); #1;
         if (bus.busy) late_busy++;
      end
      checks++;
      if (n != 11 || late_busy != 0) begin
         errors++;
         $display("FAIL drop_while_busy: remaining busy=%0d later busy=%0d required 11 and 0", n, late_busy);
      end
      capture_scan();
      for (int i = 0; i < ND; i++) begin
         checks++;
         if (cap_ok !== 1'b1 || cap_com[i] !== exp_com(i) || cap_data[i] !== exp[i]) begin
            errors++;
            $display("FAIL b2b_digit%0d: com=%b data=%h required com=%b data=%h",
                     i, cap_com[i], cap_data[i], exp_com(i), exp[i]);
         end
      end
   endtask

   task automatic test_reset_mid_conv();
      blank_lz = 1'b0;
      @(negedge clk);
      bus.value_i = 14'd4321;
      bus.value_valid = 1'b1;
      @(posedge clk); #1;
      bus.value_valid = 1'b0;
      repeat (5) @(posedge clk);
      @(negedge clk) rst = 1'b0;
      #1;
      checks++;
      if (bus.busy !== 1'b0 || fnd_com !== 4'b1111 || fnd_data !== 8'hFF) begin
         errors++;
         $display("FAIL reset_mid_conv: busy=%b com=%b data=%h required busy=0 com=1111 data=FF",
                  bus.busy, fnd_com, fnd_data);
      end
      repeat (2) @(negedge clk);
      rst = 1'b1;
      repeat (20) @(posedge clk);
      #1;
      checks++;
      if (bus.busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_abort_busy: busy=%b required 0", bus.busy);
      end
      capture_scan();
      for (int i = 0; i < ND; i++) begin
         checks++;
         if (cap_ok !== 1'b1 || cap_com[i] !== exp_com(i) || cap_data[i] !== 8'hC0) begin
            errors++;
            $display("FAIL reset_zero_digit%0d: com=%b data=%h required com=%b data=C0",
                     i, cap_com[i], cap_data[i], exp_com(i));
         end
      end
   endtask

   task automatic test_blink();
      int unsigned   bc;
      logic [ND-1:0] prev;
      logic [ND-1:0] exp [9];
      logic          synced;
      int unsigned   n;
      exp = '{4'b1101, 4'b1011, 4'b1111, 4'b1111, 4'b1101, 4'b1011, 4'b1111,
              4'b1110, 4'b1101};
      blank_lz = 1'b1;
      load(14'd1234, bc);
      synced = 1'b0;
      n = 0;
      while (!synced && n < 64) begin
         prev = fnd_com;
         @(posedge clk); #1;
         n++;
         if (fnd_com == 4'b1110 && prev != 4'b1110) synced = 1'b1;
      end
      checks++;
      if (!synced) begin
         errors++;
         $display("FAIL blink_sync: digit0 strobe=%b required 1", synced);
      end
      blink_en = 1'b1;
      for (int t = 0; t < 9; t++) begin
         repeat (TD) @(posedge clk);
         #1;
         checks++;
         if (fnd_com !== exp[t]) begin
            errors++;
            $display("FAIL blink_tick%0d: com=%b required %b", t + 1, fnd_com, exp[t]);
         end
         if (t == 6) blink_en = 1'b0;
      end
   endtask

   initial begin
      test_reset();
      test_load_1234();
      test_blanking();
      test_overflow();
      test_back_to_back();
      test_reset_mid_conv();
      test_blink();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/fnd_scan_ctrl.md
Name: fnd_scan_ctrl

Overview:
Parametrised multi-digit 7-segment (FND) scan controller for the board display path.
- Accepts a binary value through a valid/busy handshake.
- Converts it to BCD sequentially with a double-dabble engine, one shift per clock.
- Time-multiplexes NUM_DIGITS common-anode digits, with leading-zero blanking, per-digit decimal points, overflow dashes and a blink mode.
- Sits between counter/UART status logic and the board FND pins.

Parameters:
NUM_DIGITS, 4, number of digits scanned (2..8)
VALUE_W, 14, width of the binary input value
TICK_DIV, 100000, clk cycles per digit slot (1 kHz scan at 100 MHz)
BLINK_TICKS, 500, digit-slot ticks per blink half-period

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-low (asserted when 0)
value_i  in  VALUE_W  binary value to display
value_valid  in  1  request to load value_i
busy  out  1  conversion in progress; value_valid is ignored while high
ovf  out  1  displayed value exceeds 10^NUM_DIGITS-1
blank_lz  in  1  enable leading-zero blanking
dp_mask  in  NUM_DIGITS  per-digit decimal point enable (bit0 = ones digit)
blink_en  in  1  enable display blinking
fnd_com  out  NUM_DIGITS  digit enables, active-low, registered
fnd_data  out  8  segments, active-low; [7]=dp, [6:0]=g..a, registered

Behaviour:
- Reset (rst=0, async):
  - fnd_com all ones, fnd_data 8'hFF, busy 0, ovf 0.
  - Display BCD register 0; scan index, tick counter and blink phase 0.
  - Any conversion in progress is aborted.
- Handshake:
  - Accept on the clk edge where value_valid=1 and busy=0.
  - value_i is captured into the shift register on that edge.
  - value_valid while busy=1 is dropped, with no queueing.
- Conversion FSM:
  - IDLE -> CONV on accept.
  - CONV: VALUE_W cycles. Each cycle adds 3 to every BCD nibble >=5, then shifts left one bit.
  - CONV -> DONE after the last shift.
  - DONE: one cycle. Commits BCD to the display register, computes ovf, then returns to IDLE.
  - busy is 1 in CONV and DONE: exactly VALUE_W+1 cycles, starting the cycle after accept.
  - Display and ovf change on the DONE->IDLE edge.
- Overflow:
  - Flagged when a carry exits the top BCD nibble, i.e. value >= 10^NUM_DIGITS.
  - ovf=1 forces every digit to SEG_DASH (8'hBF; dp still honoured).
  - ovf holds until the next committed conversion.
- Scan:
  - The tick counter counts 0..TICK_DIV-1 and pulses on wrap.
  - Each tick advances the scan index modulo NUM_DIGITS (0 = ones digit).
  - fnd_com has a single 0 at the scan index bit. fnd_com and fnd_data update on the same edge, so there is no ghosting.
- Segment codes, active-low:
  - 0 C0, 1 F9, 2 A4, 3 B0, 4 99, 5 92, 6 82, 7 F8, 8 80, 9 90.
  - Bit7 is cleared when dp_mask[idx]=1.
- Leading-zero blanking:
  - Applies when blank_lz=1 and ovf=0.
  - Digit i>0 is blanked if it and every higher digit are 0; digit 0 is never blanked.
  - A blanked digit drives 8'hFF, or 8'h7F if its dp bit is set.
- Blink:
  - The phase toggles every BLINK_TICKS ticks while blink_en=1.
  - When blink_en=1 and phase=1, fnd_com is all ones.
  - When blink_en=0, phase is held at 0.
- Register timing: blank_lz, dp_mask and blink_en are sampled every cycle and take effect on the next registered output update.

Decomposition:
- Package fnd_pkg:
  - SEG_CODE[0..9], SEG_BLANK (8'hFF), SEG_DASH (8'hBF), DP_BIT (7).
  - FSM state enum: IDLE, CONV, DONE.
- One sub-module, bin2bcd_seq: the handshake, double-dabble FSM and ovf detection, parametrised by VALUE_W and NUM_DIGITS.
- The top holds the tick counter, scan index, blink phase and output mux/registers.

Test Plan:
(All scenarios use NUM_DIGITS=4, VALUE_W=14, TICK_DIV=4, BLINK_TICKS=2.)
- Reset: hold rst=0 mid-run -> immediately fnd_com=4'b1111, fnd_data=8'hFF, busy=0. Release -> scan starts with fnd_com=4'b1110 after the first tick.
- Load 1234 (one-cycle pulse) -> busy high for exactly 15 cycles, then the scan shows:
  - com 1110/data 99
  - com 1101/B0
  - com 1011/A4
  - com 0111/F9
- Load 7: with blank_lz=1 -> digits 1..3 show FF, digit0 F8. With blank_lz=0 -> digits 1..3 show C0. With dp_mask=4'b0100 -> digit2 shows 7F when blanked, 40 when unblanked.
- Load 10000 -> ovf=1, all four digits BF. Then load 9999 -> ovf=0, all digits 90.
- Load 1234, then pulse value_valid with 42 while busy=1 -> 42 is ignored, display ends at 1234. Asserting rst mid-CONV -> busy=0 and display returns to 0 (digit0 C0).
- blink_en=1 with value 1234 -> fnd_com alternates: 2 ticks of scanning, then 2 ticks of 4'b1111, repeating. Dropping blink_en -> scanning resumes on the next tick.
